// File: rtl/muap_packer.sv
`default_nettype none
// muap_packer: assembles muap beats into spikes in a two-slot ping-pong buffer
// and streams each spike downstream as three header words plus SPK_LEN samples.
module muap_packer #(
  parameter int SPK_LEN = 19,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             muap_stream_TVALID,
  output logic             muap_stream_TREADY,
  input  logic [31:0]      muap_stream_TUSER,
  input  logic [7:0]       muap_stream_TID,
  input  logic [31:0]      muap_stream_TDEST,
  input  logic [31:0]      muap_stream_TDATA,
  input  logic             spk_full,
  output logic             spk_wr_en,
  output logic [31:0]      spk_data,
  output logic             spk_last,
  output logic [31:0]      spk_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             err_pulse
);

  localparam int               IDX_W    = $clog2(SPK_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPK_LEN - 1);
  localparam logic [15:0]      LEN_WORD = 16'(SPK_LEN);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, DATA} state_t;
  state_t state, state_nxt;

  logic [1:0]       slot_full;
  logic             wr_slot, rd_slot;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [31:0]      frame_q [2];
  logic [7:0]       ch_q    [2];
  logic [31:0]      hash_q  [2];
  logic [31:0]      samples [2][SPK_LEN];

  logic accept, mismatch, restart, commit, release_slot;

  assign muap_stream_TREADY = ~slot_full[wr_slot];
  assign accept   = muap_stream_TVALID & muap_stream_TREADY;
  assign mismatch = accept && (wr_idx != '0) &&
                    ((muap_stream_TUSER != frame_q[wr_slot]) || (muap_stream_TID != ch_q[wr_slot]));
  // A mismatching beat is not discarded: it opens a new spike in the same slot.
  assign restart  = accept && ((wr_idx == '0) || mismatch);
  assign commit   = accept && !mismatch && (wr_idx == LAST_IDX);

  assign spk_wr_en    = (state != IDLE) && !spk_full;
  assign release_slot = spk_wr_en && (state == DATA) && (rd_idx == LAST_IDX);

  // Payload storage carries no reset; slot_full alone says what is valid.
  always_ff @(posedge clk) begin
    if (restart) begin
      frame_q[wr_slot] <= muap_stream_TUSER;
      ch_q[wr_slot]    <= muap_stream_TID;
      hash_q[wr_slot]  <= muap_stream_TDEST;
    end
    if (accept) begin
      samples[wr_slot][mismatch ? '0 : wr_idx] <= muap_stream_TDATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_slot    <= 1'b0;
      wr_idx     <= '0;
      err_pulse  <= 1'b0;
      drop_count <= '0;
    end else begin
      err_pulse <= mismatch;
      if (mismatch && (drop_count != '1)) begin
        drop_count <= drop_count + 1'b1;
      end
      if (commit) begin
        wr_idx  <= '0;
        wr_slot <= ~wr_slot;
      end else if (accept) begin
        wr_idx <= mismatch ? IDX_W'(1) : wr_idx + 1'b1;
      end
    end
  end

  // Commit and release always target different slots, so both may land on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      slot_full <= 2'b00;
      rd_slot   <= 1'b0;
      rd_idx    <= '0;
      spk_count <= '0;
    end else begin
      state <= state_nxt;
      if (commit) begin
        slot_full[wr_slot] <= 1'b1;
      end
      if (release_slot) begin
        slot_full[rd_slot] <= 1'b0;
        rd_slot            <= ~rd_slot;
        spk_count          <= spk_count + 32'd1;
      end
      if (spk_wr_en && (state == DATA)) begin
        rd_idx <= release_slot ? '0 : rd_idx + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    spk_data  = '0;
    spk_last  = 1'b0;
    case (state)
      IDLE: if (slot_full[rd_slot]) state_nxt = HDR0;
      HDR0: begin
        spk_data = {8'hA5, ch_q[rd_slot], LEN_WORD};
        if (spk_wr_en) state_nxt = HDR1;
      end
      HDR1: begin
        spk_data = frame_q[rd_slot];
        if (spk_wr_en) state_nxt = HDR2;
      end
      HDR2: begin
        spk_data = hash_q[rd_slot];
        if (spk_wr_en) state_nxt = DATA;
      end
      DATA: begin
        spk_data = samples[rd_slot][rd_idx];
        spk_last = (rd_idx == LAST_IDX);
        if (release_slot) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!spk_wr_en) begin
      spk_data = '0;
      spk_last = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muap_packer.sv
`default_nettype none
// tb_muap_packer: table-driven, directed and randomized checks of muap_packer
// against a queue-based spike/packet model.
module tb_muap_packer;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [31:0] tuser = '0, tdest = '0, tdata = '0;
  logic [7:0]  tid = '0;
  logic        spk_full = 1'b0;
  logic        spk_wr_en, spk_last, err_pulse;
  logic [31:0] spk_data, spk_count;
  logic [15:0] drop_count;

  muap_packer #(.SPK_LEN(L), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .muap_stream_TVALID(tvalid), .muap_stream_TREADY(tready),
    .muap_stream_TUSER(tuser), .muap_stream_TID(tid),
    .muap_stream_TDEST(tdest), .muap_stream_TDATA(tdata),
    .spk_full(spk_full), .spk_wr_en(spk_wr_en), .spk_data(spk_data),
    .spk_last(spk_last), .spk_count(spk_count), .drop_count(drop_count),
    .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // spk_full driver: 0 = manual level, 1 = toggle each cycle, 2 = random
  int   full_mode = 0;
  logic full_man = 1'b0;
  always @(posedge clk) begin
    #2;
    case (full_mode)
      0: spk_full = full_man;
      1: spk_full = ~spk_full;
      default: spk_full = ($urandom_range(0, 2) == 0);
    endcase
  end

  // Reference model: spikes built from accepted beats, packets as word queues.
  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];
  logic [32:0] want_q[$];
  logic [31:0] cur[$];
  logic [31:0] cur_t, cur_h;
  logic [7:0]  cur_ch;
  int pending = 0, m_spk = 0, m_drop = 0, err_seen = 0;
  logic m_err = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      got_q.delete(); exp_q.delete(); cur.delete();
      pending = 0; m_spk = 0; m_drop = 0; m_err = 1'b0;
    end else begin
      chk("tready", tready, pending < 2);
      chk("err_pulse", err_pulse, m_err);
      chk("spk_count", spk_count, m_spk);
      chk("drop_count", drop_count, m_drop);
      if (err_pulse) err_seen++;
      m_err = 1'b0;
      if (!spk_wr_en) begin
        chk("idle_bus", {spk_last, spk_data}, 33'd0);
      end else begin
        got_q.push_back({spk_last, spk_data});
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word actual=%0h required=none", {spk_last, spk_data});
        end else begin
          chk("word", {spk_last, spk_data}, exp_q.pop_front());
        end
        if (spk_last) begin
          pending--;
          m_spk++;
        end
      end
      if (tvalid && tready) begin
        if (cur.size() > 0 && (tuser != cur_t || tid != cur_ch)) begin
          cur.delete();
          m_err = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
        if (cur.size() == 0) begin
          cur_t = tuser; cur_ch = tid; cur_h = tdest;
        end
        cur.push_back(tdata);
        if (cur.size() == L) begin
          exp_q.push_back({1'b0, 8'hA5, cur_ch, 16'(L)});
          exp_q.push_back({1'b0, cur_t});
          exp_q.push_back({1'b0, cur_h});
          for (int k = 0; k < L; k++) exp_q.push_back({k == L - 1, cur[k]});
          cur.delete();
          pending++;
        end
      end
    end
  end

  task automatic send(input logic [31:0] t, input logic [7:0] ch, input logic [31:0] h,
                      input logic [31:0] d);
    int n = 0;
    tvalid = 1'b1; tuser = t; tid = ch; tdest = h; tdata = d;
    while (!tready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (!tready) begin
      checks++; errors++;
      $display("FAIL send_timeout tready=0 required=1");
    end else begin
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
  endtask

  task automatic send_spike(input logic [31:0] t, input logic [7:0] ch, input logic [31:0] h,
                            input logic [31:0] d0);
    for (int k = 0; k < L; k++) send(t, ch, (k == 0) ? h : ~h, d0 + 32'(k));
  endtask

  task automatic expect_pkt(input logic [31:0] t, input logic [7:0] ch, input logic [31:0] h,
                            input logic [31:0] d0);
    want_q.push_back({1'b0, 8'hA5, ch, 16'h0004});
    want_q.push_back({1'b0, t});
    want_q.push_back({1'b0, h});
    for (int k = 0; k < L; k++) want_q.push_back({k == L - 1, d0 + 32'(k)});
  endtask

  task automatic wait_words(input int n, input int limit);
    int c = 0;
    while (got_q.size() < n && c < limit) begin
      @(negedge clk); c++;
    end
    chk("wait_words", got_q.size() >= n, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic compare_got(input string name);
    chk({name, "_len"}, got_q.size(), want_q.size());
    foreach (want_q[i]) if (i < got_q.size()) chk(name, got_q[i], want_q[i]);
    got_q.delete(); want_q.delete();
  endtask

  typedef struct packed {
    logic [31:0]       t;
    logic [7:0]        ch;
    logic [31:0]       h;
    logic [3:0][31:0]  d;
    logic [6:0][31:0]  w;
  } vec_t;
  vec_t vt [3];

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0].t = 32'd100;       vt[0].ch = 8'd7;    vt[0].h = 32'h0102_0304;
    vt[0].d = {32'd4, 32'd3, 32'd2, 32'd1};
    vt[0].w = {32'd4, 32'd3, 32'd2, 32'd1, 32'h0102_0304, 32'h0000_0064, 32'hA507_0004};
    vt[1].t = 32'hDEAD_BEEF; vt[1].ch = 8'hFF;   vt[1].h = 32'hFFFF_FFFF;
    vt[1].d = {32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 32'h0};
    vt[1].w = {32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF,
               32'hDEAD_BEEF, 32'hA5FF_0004};
    vt[2].t = 32'd0;         vt[2].ch = 8'h80;   vt[2].h = 32'd0;
    vt[2].d = {32'h13, 32'h12, 32'h11, 32'h10};
    vt[2].w = {32'h13, 32'h12, 32'h11, 32'h10, 32'h0, 32'h0, 32'hA580_0004};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", tready, 1'b1);
    chk("rst_wr_en", spk_wr_en, 1'b0);
    chk("rst_counts", {spk_count, drop_count, err_pulse}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven single packets with latency check
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < L; k++) send(vt[i].t, vt[i].ch, (k == 0) ? vt[i].h : ~vt[i].h, vt[i].d[k]);
      @(negedge clk);
      chk("lat_idle", spk_wr_en, 1'b0);
      @(negedge clk);
      chk("lat_hdr0", {spk_wr_en, spk_data}, {1'b1, vt[i].w[0]});
      wait_words(7, 50);
      for (int k = 0; k < 7; k++) want_q.push_back({k == 6, vt[i].w[k]});
      compare_got("tbl_pkt");
      chk("tbl_spk_count", spk_count, 32'(i + 1));
    end

    // Mismatch aborts the partial spike
    begin
      int e0 = err_seen;
      send(5, 1, 32'hAA, 32'h10);
      send(5, 1, 32'hAA, 32'h11);
      send_spike(6, 1, 32'hBB, 32'h20);
      wait_words(7, 50);
      expect_pkt(6, 1, 32'hBB, 32'h20);
      compare_got("mis_pkt");
      chk("mis_err_cycles", err_seen - e0, 1);
      chk("mis_drop", drop_count, 16'd1);
    end

    // Two spikes back-to-back, third while downstream is full
    full_man = 1'b1;
    send_spike(10, 2, 32'h1111, 32'h100);
    send_spike(11, 3, 32'h2222, 32'h200);
    @(negedge clk);
    chk("b2b_tready_low", tready, 1'b0);
    @(posedge clk); #1;
    fork
      send_spike(12, 4, 32'h3333, 32'h300);
      begin
        repeat (10) @(posedge clk);
        #1;
        chk("b2b_hold_tready", tready, 1'b0);
        chk("b2b_hold_words", got_q.size(), 0);
        full_man = 1'b0;
      end
    join
    wait_words(21, 100);
    expect_pkt(10, 2, 32'h1111, 32'h100);
    expect_pkt(11, 3, 32'h2222, 32'h200);
    expect_pkt(12, 4, 32'h3333, 32'h300);
    compare_got("b2b");

    // spk_full toggling every cycle
    full_mode = 1;
    send_spike(20, 5, 32'h5555, 32'h500);
    wait_words(7, 100);
    repeat (10) @(negedge clk);
    begin
      int lasts = 0;
      foreach (got_q[i]) if (got_q[i][32]) lasts++;
      chk("tog_lasts", lasts, 1);
    end
    expect_pkt(20, 5, 32'h5555, 32'h500);
    compare_got("tog");
    full_mode = 0;
    full_man = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset during DATA word 2
    send_spike(30, 6, 32'h6666, 32'h600);
    begin
      int c = 0;
      while (got_q.size() < 5 && c < 50) begin
        @(negedge clk); c++;
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wr_en", spk_wr_en, 1'b0);
    chk("rst_mid_bus", {spk_last, spk_data}, 33'd0);
    chk("rst_mid_tready", tready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_no_words", got_q.size(), 0);
    chk("rst_counts_after", {spk_count, drop_count}, '0);
    send_spike(31, 9, 32'h9999, 32'h900);
    wait_words(7, 50);
    expect_pkt(31, 9, 32'h9999, 32'h900);
    compare_got("rst_fresh");

    // Commit of one slot on the same edge the other is released
    send_spike(40, 1, 32'h4040, 32'h400);
    repeat (4) @(posedge clk);
    #1;
    send_spike(41, 2, 32'h4141, 32'h410);
    chk("sim_first_done", got_q.size(), 7);
    @(negedge clk);
    chk("sim_gap", spk_wr_en, 1'b0);
    @(negedge clk);
    chk("sim_hdr0", {spk_wr_en, spk_data}, {1'b1, 32'hA502_0004});
    wait_words(14, 50);
    expect_pkt(40, 1, 32'h4040, 32'h400);
    expect_pkt(41, 2, 32'h4141, 32'h410);
    compare_got("sim");

    // Randomized traffic against the model
    full_mode = 2;
    begin
      logic [31:0] t = 1;
      logic [7:0]  ch = 1;
      for (int i = 0; i < 400; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        if ($urandom_range(0, 11) == 0) t = 32'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) ch = 8'($urandom_range(0, 2));
        send(t, ch, $urandom, $urandom);
      end
    end
    begin
      int c = 0;
      while (pending != 0 && c < 300) begin
        @(negedge clk); c++;
      end
    end
    chk("rand_drained", pending, 0);
    chk("rand_exp_left", exp_q.size(), 0);
    chk("rand_spk_count", spk_count, 32'(m_spk));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
